vx_cluster_dcr_fanout: RTL and testbench

Multi-socket successor to the single-socket top-level wrapper. Takes the flattened DCR write interface from the host, fans each write out to NUM_SOCKETS sockets through a configurable register pipeline under a runtime socket-enable mask, and folds per-socket busy flags plus in-flight DCR traffic into one cluster busy output. Sits between the host DCR port and the socket array in the multi-socket top level.

---
 rtl/VX_gpu_pkg.sv | 24 ++
 rtl/vx_busy_hyst.sv | 74 +++++++
 rtl/vx_cluster_dcr_fanout.sv | 83 ++++++++
 tb/tb_vx_cluster_dcr_fanout.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/VX_gpu_pkg.sv
// Shared DCR widths, socket-mask register address, fan-out stage payload and busy FSM states.
// Type and constant definitions only; no logic, no latency, no flow control.
// Stage valid vectors are sized for the largest cluster so one type serves every build.
package VX_gpu_pkg;

  localparam int VX_DCR_ADDR_WIDTH = 12;
  localparam int VX_DCR_DATA_WIDTH = 32;
  localparam int MAX_NUM_SOCKETS   = 16;

  localparam logic [VX_DCR_ADDR_WIDTH-1:0] VX_DCR_SOCKET_MASK_ADDR = 12'h00C;

  typedef struct packed {
    logic [MAX_NUM_SOCKETS-1:0]   valid;
    logic [VX_DCR_ADDR_WIDTH-1:0] addr;
    logic [VX_DCR_DATA_WIDTH-1:0] data;
  } dcr_fanout_stage_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } busy_state_e;

endpackage

// File: rtl/vx_busy_hyst.sv
// Registered cluster busy from raw_busy; optional idle hysteresis under VX_CLUSTER_BUSY_HYST_EN.
// Latency: rises one edge after raw_busy; falls after IDLE_HOLD idle edges (hysteresis) or one edge.
// No backpressure: pure status path.
module vx_busy_hyst
  import VX_gpu_pkg::*;
#(
  parameter int IDLE_HOLD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_busy,
  output logic busy
);

  busy_state_e state_q, state_d;

`ifdef VX_CLUSTER_BUSY_HYST_EN
  localparam int CW = $clog2(IDLE_HOLD + 1);

  logic [CW-1:0] idle_cnt_q, idle_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (raw_busy) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (!raw_busy) begin
          state_d    = (IDLE_HOLD == 1) ? ST_IDLE : ST_DRAIN;
          idle_cnt_d = CW'(1);
        end
      end
      ST_DRAIN: begin
        if (raw_busy) begin
          state_d    = ST_BUSY;
          idle_cnt_d = '0;
        end else begin
          // counter saturates rather than wrapping
          if (idle_cnt_q != '1) idle_cnt_d = idle_cnt_q + CW'(1);
          if (idle_cnt_q == CW'(IDLE_HOLD - 1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
`else
  logic unused_idle_hold;
  assign unused_idle_hold = (IDLE_HOLD == 0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = raw_busy ? ST_BUSY : ST_IDLE;
  end
`endif

  assign busy = (state_q != ST_IDLE);

endmodule

// File: rtl/vx_cluster_dcr_fanout.sv
// Fans host DCR writes to NUM_SOCKETS sockets via a masked register pipeline; folds busy (VX_CLUSTER_BUSY_HYST_EN).
// Latency: write accepted at edge t reaches socket_* after edge t+DCR_PIPE_STAGES-1.
// No backpressure: one write per cycle; mask-register writes are consumed locally.
module vx_cluster_dcr_fanout
  import VX_gpu_pkg::*;
#(
  parameter int NUM_SOCKETS     = 4,
  parameter int DCR_PIPE_STAGES = 2,
  parameter int IDLE_HOLD       = 4,
  parameter logic [VX_DCR_ADDR_WIDTH-1:0] MASK_ADDR = VX_DCR_SOCKET_MASK_ADDR
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         write_valid,
  input  logic [VX_DCR_ADDR_WIDTH-1:0] write_addr,
  input  logic [VX_DCR_DATA_WIDTH-1:0] write_data,
  output logic [NUM_SOCKETS-1:0]       socket_write_valid,
  output logic [VX_DCR_ADDR_WIDTH-1:0] socket_write_addr,
  output logic [VX_DCR_DATA_WIDTH-1:0] socket_write_data,
  input  logic [NUM_SOCKETS-1:0]       socket_busy,
  output logic [NUM_SOCKETS-1:0]       socket_mask,
  output logic                         busy
);

  logic [NUM_SOCKETS-1:0]     mask_q;
  logic [MAX_NUM_SOCKETS-1:0] mask_ext;
  logic                       is_mask_wr;
  logic                       accept;
  logic                       raw_busy;
  logic [DCR_PIPE_STAGES-1:0] stage_act;

  dcr_fanout_stage_t stage_q [DCR_PIPE_STAGES];
  dcr_fanout_stage_t stage_d [DCR_PIPE_STAGES];

  always_comb begin
    mask_ext                = '0;
    mask_ext[NUM_SOCKETS-1:0] = mask_q;
  end

  assign is_mask_wr = write_valid && (write_addr == MASK_ADDR);
  // an all-zero mask drops the write at entry so it never occupies a stage
  assign accept     = write_valid && (write_addr != MASK_ADDR) && (mask_q != '0);

  always_ff @(posedge clk) begin
    if (reset)           mask_q <= '1;
    else if (is_mask_wr) mask_q <= write_data[NUM_SOCKETS-1:0];
  end

  for (genvar g = 0; g < DCR_PIPE_STAGES; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign stage_d[g] = accept ? {mask_ext, write_addr, write_data}
                                 : {{MAX_NUM_SOCKETS{1'b0}}, stage_q[g].addr, stage_q[g].data};
    end else begin : g_body
      assign stage_d[g] = (|stage_q[g-1].valid) ? stage_q[g-1]
                        : {{MAX_NUM_SOCKETS{1'b0}}, stage_q[g].addr, stage_q[g].data};
    end
    assign stage_act[g] = |stage_q[g].valid;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DCR_PIPE_STAGES; i++) begin
      if (reset) stage_q[i] <= '0;
      else       stage_q[i] <= stage_d[i];
    end
  end

  assign socket_write_valid = stage_q[DCR_PIPE_STAGES-1].valid[NUM_SOCKETS-1:0];
  assign socket_write_addr  = stage_q[DCR_PIPE_STAGES-1].addr;
  assign socket_write_data  = stage_q[DCR_PIPE_STAGES-1].data;
  assign socket_mask        = mask_q;

  assign raw_busy = (|socket_busy) || (|stage_act);

  vx_busy_hyst #(
    .IDLE_HOLD (IDLE_HOLD)
  ) u_busy_hyst (
    .clk      (clk),
    .reset    (reset),
    .raw_busy (raw_busy),
    .busy     (busy)
  );

endmodule

// File: tb/tb_vx_cluster_dcr_fanout.sv
// Bench for vx_cluster_dcr_fanout: queue-based reference model checked every cycle, plus literal checks.
// Honours VX_CLUSTER_BUSY_HYST_EN to select the expected busy behaviour.
module tb_vx_cluster_dcr_fanout;
  import VX_gpu_pkg::*;

  localparam int NS   = 4;
  localparam int PS   = 2;
  localparam int HOLD = 4;
  localparam logic [VX_DCR_ADDR_WIDTH-1:0] MA = VX_DCR_SOCKET_MASK_ADDR;
`ifdef VX_CLUSTER_BUSY_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         write_valid;
  logic [VX_DCR_ADDR_WIDTH-1:0] write_addr;
  logic [VX_DCR_DATA_WIDTH-1:0] write_data;
  logic [NS-1:0]                socket_write_valid;
  logic [VX_DCR_ADDR_WIDTH-1:0] socket_write_addr;
  logic [VX_DCR_DATA_WIDTH-1:0] socket_write_data;
  logic [NS-1:0]                socket_busy;
  logic [NS-1:0]                socket_mask;
  logic                         busy;

  int total = 0;
  int bad   = 0;

  vx_cluster_dcr_fanout #(
    .NUM_SOCKETS     (NS),
    .DCR_PIPE_STAGES (PS),
    .IDLE_HOLD       (HOLD),
    .MASK_ADDR       (MA)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .write_valid        (write_valid),
    .write_addr         (write_addr),
    .write_data         (write_data),
    .socket_write_valid (socket_write_valid),
    .socket_write_addr  (socket_write_addr),
    .socket_write_data  (socket_write_data),
    .socket_busy        (socket_busy),
    .socket_mask        (socket_mask),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: each accepted write is scheduled for the edge it must appear after
  typedef struct {
    int                           due;
    logic [NS-1:0]                vld;
    logic [VX_DCR_ADDR_WIDTH-1:0] addr;
    logic [VX_DCR_DATA_WIDTH-1:0] data;
  } ent_t;

  ent_t                         q[$];
  int                           ec = 0;
  int                           idle_run = 0;
  bit                           model_ok = 1'b0;
  logic [NS-1:0]                m_vld, m_mask;
  logic [VX_DCR_ADDR_WIDTH-1:0] m_addr;
  logic [VX_DCR_DATA_WIDTH-1:0] m_data;
  logic                         m_busy;

  always @(posedge clk) begin
    ent_t e;
    bit   raw;
    ec++;
    if (reset) begin
      q.delete();
      m_vld = '0; m_addr = '0; m_data = '0; m_mask = '1; m_busy = 1'b0;
      idle_run = 0;
      model_ok = 1'b1;
    end else begin
      // a write is still in a stage at edge ec if it is due at ec-1 or later
      while (q.size() > 0 && q[0].due < ec - 1) void'(q.pop_front());
      raw = (|socket_busy) || (q.size() > 0);
      if (HYST) begin
        idle_run = raw ? 0 : idle_run + 1;
        m_busy   = m_busy ? (raw || idle_run < HOLD) : raw;
      end else begin
        m_busy = raw;
      end
      if (write_valid && write_addr != MA && m_mask != '0) begin
        e.due = ec + PS - 1; e.vld = m_mask; e.addr = write_addr; e.data = write_data;
        q.push_back(e);
      end
      m_vld = '0;
      foreach (q[i]) begin
        if (q[i].due == ec) begin
          m_vld = q[i].vld; m_addr = q[i].addr; m_data = q[i].data;
        end
      end
      if (write_valid && write_addr == MA) m_mask = write_data[NS-1:0];
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("valid", socket_write_valid, m_vld);
      chk("addr",  socket_write_addr,  m_addr);
      chk("data",  socket_write_data,  m_data);
      chk("mask",  socket_mask,        m_mask);
      chk("busy",  busy,               m_busy);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [VX_DCR_ADDR_WIDTH-1:0] a, input logic [VX_DCR_DATA_WIDTH-1:0] d);
    write_valid = 1'b1; write_addr = a; write_data = d;
    step(1);
    write_valid = 1'b0;
  endtask

  task automatic pulse_busy();
    socket_busy = 4'b1000;
    step(1);
    socket_busy = '0;
  endtask

  task automatic count_busy(input string nm, input int exp);
    int n = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      n++;
      step(1);
    end
    chk(nm, n, exp);
  endtask

  initial begin
    reset = 1'b1; write_valid = 1'b0; write_addr = '0; write_data = '0; socket_busy = '0;
    step(2);
    reset = 1'b0;
    chk("rst_mask",  socket_mask, 4'hF);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_valid", socket_write_valid, 4'h0);
    chk("rst_data",  socket_write_data, 32'h0);
    step(2);

    wr(12'h001, 32'hAB);
    step(1);
    chk("first_valid", socket_write_valid, 4'hF);
    chk("first_data",  socket_write_data, 32'hAB);
    chk("first_busy",  busy, 1'b1);
    step(10);

    wr(MA, 32'h5);
    wr(12'h002, 32'h77);
    step(1);
    chk("mask5_valid", socket_write_valid, 4'b0101);
    chk("mask5_addr",  socket_write_addr, 12'h002);
    step(10);

    wr(MA, 32'h0);
    wr(12'h003, 32'h33);
    step(1);
    chk("mask0_valid", socket_write_valid, 4'h0);
    chk("mask0_busy",  busy, 1'b0);
    step(3);

    wr(MA, 32'hF);
    wr(12'h010, 32'hA0);
    wr(12'h011, 32'hA1);
    wr(MA, 32'h3);
    wr(12'h012, 32'hA2);
    wr(12'h013, 32'hA3);
    step(1);
    chk("b2b_last_valid", socket_write_valid, 4'b0011);
    chk("b2b_last_data",  socket_write_data, 32'hA3);
    step(10);

    pulse_busy();
    count_busy("pulse_hold", HYST ? HOLD : 1);
    step(5);

    pulse_busy();
    step(2);
    chk("drain_mid", busy, HYST ? 1'b1 : 1'b0);
    pulse_busy();
    count_busy("reassert_hold", HYST ? HOLD : 1);
    step(5);

    wr(MA, 32'h2);
    wr(12'h020, 32'hCC);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("midrst_valid", socket_write_valid, 4'h0);
    chk("midrst_busy",  busy, 1'b0);
    chk("midrst_mask",  socket_mask, 4'hF);
    step(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
